hll_register_bank: RTL and testbench

HyperLogLog register bank for the HLL kernel. It consumes (bucket index, rank) pairs from the leading-bit stage and keeps, per bucket, the maximum rank seen. On request it streams all buckets out in index order over a valid/ready interface to the estimator, clearing each bucket as it is read. Storage is a single-port-per-side RAM behind a 3-stage read-modify-write pipeline with same-index forwarding.

---
 rtl/hll_register_bank.sv | 172 +++++++++++++++++
 tb/tb_hll_register_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hll_register_bank.sv
// HyperLogLog register bank: keeps the maximum rank per bucket through a
// read-modify-write pipeline and streams the bank out, clearing each entry on read.
module hll_register_bank #(
  parameter int IDX_W  = 8,
  parameter int RANK_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [RANK_W-1:0] in_rank,
  input  logic              in_valid,
  output logic              ready,
  input  logic              drain_start,
  output logic [IDX_W-1:0]  out_index,
  output logic [RANK_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  typedef enum logic [1:0] {CLEAR, ACCUM, FLUSH, DRAIN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic              flush_cnt;

  logic [RANK_W-1:0] mem [DEPTH];
  logic [RANK_W-1:0] rd_q;
  logic [IDX_W-1:0]  rd_addr;
  logic              we;
  logic [IDX_W-1:0]  wr_addr;
  logic [RANK_W-1:0] wr_data;

  logic              s0_valid;
  logic [IDX_W-1:0]  s0_idx;
  logic [RANK_W-1:0] s0_rank;
  logic              s1_valid;
  logic [IDX_W-1:0]  s1_idx;
  logic [RANK_W-1:0] s1_rank;
  logic              s2_valid;
  logic [IDX_W-1:0]  s2_idx;
  logic [RANK_W-1:0] s2_val;

  logic [RANK_W-1:0] s1_old;
  logic [RANK_W-1:0] s1_new;
  logic              accept;
  logic              handshake;

  assign accept    = in_valid & ready;
  assign handshake = out_valid & out_ready;
  assign out_data  = out_valid ? rd_q : '0;

  // The RAM read of an update overlaps the write of the update just ahead of it,
  // so that single in-flight result is the only one that ever needs forwarding.
  always_comb begin
    rd_addr = (state == DRAIN) ? cnt : s0_idx;
    s1_old  = (s2_valid && (s2_idx == s1_idx)) ? s2_val : rd_q;
    s1_new  = (s1_rank > s1_old) ? s1_rank : s1_old;
    we      = 1'b0;
    wr_addr = s1_idx;
    wr_data = s1_new;
    if (!rst) begin
      case (state)
        CLEAR: begin
          we      = 1'b1;
          wr_addr = cnt;
          wr_data = '0;
        end
        DRAIN: begin
          if (handshake) begin
            we      = 1'b1;
            wr_addr = cnt;
            wr_data = '0;
          end
        end
        default: we = s1_valid;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_idx   <= '0;
      s0_rank  <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_rank  <= '0;
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_val   <= '0;
    end else begin
      s0_valid <= accept;
      s0_idx   <= in_index;
      s0_rank  <= in_rank;
      s1_valid <= s0_valid;
      s1_idx   <= s0_idx;
      s1_rank  <= s0_rank;
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      s2_val   <= s1_new;
    end
  end

  // cnt walks the clear addresses and then the drain addresses; it wraps to zero
  // at the end of both, so it is always zero when a drain begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      flush_cnt <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + IDX_W'(1);
          if (cnt == LAST_IDX) begin
            state <= ACCUM;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ACCUM: begin
          if (drain_start) begin
            state     <= FLUSH;
            flush_cnt <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_index <= cnt;
            out_last  <= (cnt == LAST_IDX);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cnt       <= cnt + IDX_W'(1);
            if (out_last) begin
              state <= ACCUM;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_hll_register_bank.sv
// Testbench for hll_register_bank: a cycle-level behavioural model checked every
// cycle, plus hand-computed drain contents for each directed scenario.
module tb_hll_register_bank;
  localparam int IDX_W  = 4;
  localparam int RANK_W = 5;
  localparam int N      = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [IDX_W-1:0]  in_index;
  logic [RANK_W-1:0] in_rank;
  logic              in_valid;
  logic              ready;
  logic              drain_start;
  logic [IDX_W-1:0]  out_index;
  logic [RANK_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  always #5 clk = ~clk;

  hll_register_bank #(.IDX_W(IDX_W), .RANK_W(RANK_W)) dut (
    .clk(clk), .rst(rst),
    .in_index(in_index), .in_rank(in_rank), .in_valid(in_valid),
    .ready(ready), .drain_start(drain_start),
    .out_index(out_index), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  typedef enum int {M_CLEAR, M_ACCUM, M_FLUSH, M_DRAIN} mmode_t;
  mmode_t m_mode  = M_CLEAR;
  int     m_left  = 0;
  int     m_next  = 0;
  bit     m_vld   = 1'b0;
  bit     m_known = 1'b0;
  int     m_bucket [N];

  int drained [N];
  int hs_idx  [N];
  int hs_total = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sample one cycle at the falling edge, compare, then advance.
  always @(negedge clk) begin
    if (m_known) begin
      checkOutput("ready", ready, (m_mode == M_ACCUM));
      checkOutput("busy", busy, (m_mode != M_ACCUM));
      checkOutput("out_valid", out_valid, m_vld);
      checkOutput("out_last", out_last, (m_vld && m_next == N - 1));
      if (m_vld) begin
        checkOutput("out_index", out_index, m_next);
        checkOutput("out_data", out_data, m_bucket[m_next]);
      end
      if (out_valid && out_ready) begin
        drained[out_index] = int'(out_data);
        hs_idx[out_index]++;
        hs_total++;
      end
    end
    if (rst) begin
      m_mode  = M_CLEAR;
      m_left  = N;
      m_vld   = 1'b0;
      m_next  = 0;
      m_known = 1'b1;
      for (int i = 0; i < N; i++) m_bucket[i] = 0;
    end else if (m_known) begin
      case (m_mode)
        M_CLEAR: begin
          m_left--;
          if (m_left == 0) m_mode = M_ACCUM;
        end
        M_ACCUM: begin
          if (in_valid && int'(in_rank) > m_bucket[in_index]) m_bucket[in_index] = int'(in_rank);
          if (drain_start) begin
            m_mode = M_FLUSH;
            m_left = 2;
          end
        end
        M_FLUSH: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_DRAIN;
            m_next = 0;
            m_vld  = 1'b0;
          end
        end
        M_DRAIN: begin
          if (!m_vld) m_vld = 1'b1;
          else if (out_ready) begin
            m_bucket[m_next] = 0;
            m_vld = 1'b0;
            if (m_next == N - 1) m_mode = M_ACCUM;
            else m_next++;
          end
        end
        default: m_mode = M_CLEAR;
      endcase
    end
  end

  task automatic setInputs(input bit r, input bit v, input int idx, input int rank,
                           input bit ds, input bit rdy);
    rst         = r;
    in_valid    = v;
    in_index    = IDX_W'(idx);
    in_rank     = RANK_W'(rank);
    drain_start = ds;
    out_ready   = rdy;
  endtask

  task automatic applyStimulus(input bit r, input bit v, input int idx, input int rank,
                               input bit ds, input bit rdy);
    @(posedge clk);
    #1;
    setInputs(r, v, idx, rank, ds, rdy);
  endtask

  // Called in the first cycle with rst low; CLEAR must last exactly N cycles.
  task automatic waitClear();
    int n = 0;
    while (!ready && n < 4 * N) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      n++;
    end
    checkOutput("clear_cycles", n, N);
  endtask

  task automatic doDrain(input int stall_at, input int abort_at,
                         input bit ds_v, input int ds_idx, input int ds_rank,
                         input bit late_v, input int late_idx, input int late_rank);
    int stalled = 0;
    bit done = 1'b0;
    for (int i = 0; i < N; i++) begin
      drained[i] = -1;
      hs_idx[i]  = 0;
    end
    hs_total = 0;
    applyStimulus(0, ds_v, ds_idx, ds_rank, 1, 1);
    for (int c = 0; c < 8 * N && !done; c++) begin
      @(posedge clk);
      #1;
      setInputs(0, 0, 0, 0, 0, 1);
      if (late_v && c == 4) begin
        setInputs(0, 1, late_idx, late_rank, 0, 1);
        checkOutput("ready_low_in_drain", ready, 0);
      end
      if (abort_at >= 0 && out_valid && int'(out_index) == abort_at) begin
        setInputs(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        setInputs(0, 0, 0, 0, 0, 1);
        checkOutput("valid_after_abort", out_valid, 0);
        waitClear();
        done = 1'b1;
      end else if (out_valid && int'(out_index) == stall_at && stalled < 5) begin
        out_ready = 1'b0;
        stalled++;
      end else if (ready) begin
        done = 1'b1;
      end
    end
    if (!done) checkOutput("drain_timeout", 0, 1);
  endtask

  task automatic checkDrain(input int e [N]);
    for (int i = 0; i < N; i++) checkOutput($sformatf("drain[%0d]", i), drained[i], e[i]);
    checkOutput("drain_count", hs_total, N);
  endtask

  initial begin
    int e [N];
    setInputs(1, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("reset_out_index", out_index, 0);
    checkOutput("reset_out_data", out_data, 0);
    waitClear();

    // Immediate drain after clear: all zeros.
    doDrain(-1, -1, 0, 0, 0, 0, 0, 0);
    e = '{default: 0};
    checkDrain(e);

    // Back-to-back updates to one index, plus a zero rank.
    applyStimulus(0, 1, 3, 5, 0, 1);
    applyStimulus(0, 1, 3, 2, 0, 1);
    applyStimulus(0, 1, 3, 7, 0, 1);
    applyStimulus(0, 1, 3, 6, 0, 1);
    applyStimulus(0, 1, 3, 0, 0, 1);
    doDrain(-1, -1, 0, 0, 0, 0, 0, 0);
    e = '{default: 0};
    e[3] = 7;
    checkDrain(e);

    // Interleaved indices.
    applyStimulus(0, 1, 1, 4, 0, 1);
    applyStimulus(0, 1, 2, 9, 0, 1);
    applyStimulus(0, 1, 1, 6, 0, 1);
    applyStimulus(0, 1, 2, 3, 0, 1);
    doDrain(-1, -1, 0, 0, 0, 0, 0, 0);
    e = '{default: 0};
    e[1] = 6;
    e[2] = 9;
    checkDrain(e);

    // Backpressure at index 5, with the largest rank value.
    applyStimulus(0, 1, 5, 31, 0, 1);
    applyStimulus(0, 1, 9, 1, 0, 1);
    applyStimulus(0, 1, 15, 2, 0, 1);
    doDrain(5, -1, 0, 0, 0, 0, 0, 0);
    e = '{default: 0};
    e[5] = 31;
    e[9] = 1;
    e[15] = 2;
    checkDrain(e);
    checkOutput("stall_handshakes_idx5", hs_idx[5], 1);
    doDrain(-1, -1, 0, 0, 0, 0, 0, 0);
    e = '{default: 0};
    checkDrain(e);

    // Update in the drain_start cycle is kept; update during DRAIN is dropped.
    doDrain(-1, -1, 1, 0, 3, 1, 4, 8);
    e = '{default: 0};
    e[0] = 3;
    checkDrain(e);
    doDrain(-1, -1, 0, 0, 0, 0, 0, 0);
    e = '{default: 0};
    checkDrain(e);

    // Reset in the middle of a drain.
    applyStimulus(0, 1, 8, 12, 0, 1);
    applyStimulus(0, 1, 2, 5, 0, 1);
    doDrain(-1, 8, 0, 0, 0, 0, 0, 0);
    checkOutput("partial_drain_idx2", drained[2], 5);
    checkOutput("abort_no_handshake_idx8", hs_idx[8], 0);
    doDrain(-1, -1, 0, 0, 0, 0, 0, 0);
    e = '{default: 0};
    checkDrain(e);

    applyStimulus(0, 0, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
